// File: rtl/aes_dec_core.sv
// aes_dec_core: iterative AES-128 decryption, key expansion then one inverse round per clock.
// Define AES_DEC_KEY_CACHE_EN to skip key expansion when the key matches the stored round key 0.
module aes_dec_core #(
  parameter int NR     = 10,
  parameter int DATA_W = 128
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              AES_en,
  input  logic [DATA_W-1:0] AES_data_in,
  input  logic [DATA_W-1:0] AES_key_in,
  output logic [DATA_W-1:0] AES_data_out,
  output logic              AES_data_out_valid,
  output logic              AES_busy
);

  if (NR != 10 || DATA_W != 128) begin : g_param_check
    $error("aes_dec_core supports only NR=10 and DATA_W=128");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEXP  = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;

  localparam logic [3:0] LAST_RND = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] bb;
    acc = 8'h00;
    p   = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ p;
      p  = xtime(p);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [2:0]   fsm_reg;
  logic [3:0]   round_reg;
  logic [127:0] state_reg;
  logic [127:0] key_work_reg;
  logic [127:0] rk_reg [0:NR];
  logic [127:0] data_out_reg;
  logic         valid_reg;
  logic         busy_reg;
  logic         key_hit;

  logic [127:0] shifted;
  logic [127:0] inv_subbed;
  logic [127:0] round_in;
  logic [127:0] round_next;
  logic [127:0] final_next;
  logic [31:0]  kw_rot;
  logic [31:0]  kw_sub;
  logic [31:0]  kw_temp;
  logic [127:0] key_next;

  // Inverse ShiftRows + InvSubBytes; byte index = 4*column + row.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int COL = gi / 4;
    localparam int ROW = gi % 4;
    localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
    assign shifted[127-8*gi -: 8]    = state_reg[127-8*SRC -: 8];
    assign inv_subbed[127-8*gi -: 8] = inv_sbox(shifted[127-8*gi -: 8]);
  end

  assign round_in   = inv_subbed ^ rk_reg[round_reg];
  assign final_next = inv_subbed ^ rk_reg[0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = round_in[127-32*gi -: 8];
    assign a1 = round_in[119-32*gi -: 8];
    assign a2 = round_in[111-32*gi -: 8];
    assign a3 = round_in[103-32*gi -: 8];
    assign round_next[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign round_next[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign round_next[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign round_next[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  // Forward key schedule step: SubWord(RotWord(w3)) ^ Rcon, then the xor chain.
  assign kw_rot = {key_work_reg[23:0], key_work_reg[31:24]};
  for (genvar gi = 0; gi < 4; gi++) begin : g_ksub
    assign kw_sub[31-8*gi -: 8] = sbox(kw_rot[31-8*gi -: 8]);
  end
  assign kw_temp = kw_sub ^ {rcon(round_reg), 24'h000000};
  assign key_next[127:96] = key_work_reg[127:96] ^ kw_temp;
  assign key_next[95:64]  = key_work_reg[95:64]  ^ key_next[127:96];
  assign key_next[63:32]  = key_work_reg[63:32]  ^ key_next[95:64];
  assign key_next[31:0]   = key_work_reg[31:0]   ^ key_next[63:32];

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid_reg;
  assign key_hit = cache_valid_reg && (AES_key_in == rk_reg[0]);
`else
  assign key_hit = 1'b0;
`endif

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm_reg      <= S_IDLE;
      round_reg    <= 4'd0;
      state_reg    <= '0;
      key_work_reg <= '0;
      rk_reg       <= '{default: '0};
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_valid_reg <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      // busy stays up for the cycle that shows valid, so accepts are spaced by an idle edge
      if (valid_reg) busy_reg <= 1'b0;
      case (fsm_reg)
        S_IDLE: begin
          if (AES_en && !busy_reg) begin
            state_reg <= AES_data_in;
            busy_reg  <= 1'b1;
            if (key_hit) begin
              fsm_reg <= S_INIT;
            end else begin
              rk_reg[0]    <= AES_key_in;
              key_work_reg <= AES_key_in;
              round_reg    <= 4'd1;
              fsm_reg      <= S_KEXP;
            end
          end
        end
        S_KEXP: begin
          rk_reg[round_reg] <= key_next;
          key_work_reg      <= key_next;
          if (round_reg == LAST_RND) begin
            fsm_reg <= S_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_valid_reg <= 1'b1;
`endif
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end
        S_INIT: begin
          state_reg <= state_reg ^ rk_reg[LAST_RND];
          round_reg <= LAST_RND - 4'd1;
          fsm_reg   <= S_ROUND;
        end
        S_ROUND: begin
          state_reg <= round_next;
          if (round_reg == 4'd1) fsm_reg <= S_FINAL;
          else round_reg <= round_reg - 4'd1;
        end
        S_FINAL: begin
          data_out_reg <= final_next;
          valid_reg    <= 1'b1;
          round_reg    <= 4'd0;
          fsm_reg      <= S_IDLE;
        end
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end

  assign AES_data_out       = data_out_reg;
  assign AES_data_out_valid = valid_reg;
  assign AES_busy           = busy_reg;

endmodule
